// File: rtl/fd_pkg.sv
// Shared types and constants for the corner-detect scan controller.
// The table below gives the 16 pixel offsets on the radius-3 circle.
package fd_pkg;

    localparam int PIX_W     = 8;
    localparam int NUM_CIRC  = 16;
    localparam int RADIUS    = 3;
    localparam int NUM_READS = NUM_CIRC + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } fdState_t;

    // Circle entries start at the top and run clockwise.
    localparam int CIRC_DX [NUM_CIRC] = '{ 0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int CIRC_DY [NUM_CIRC] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

    function automatic int circOffset(input int idx, input int imgW);
        return CIRC_DY[idx] * imgW + CIRC_DX[idx];
    endfunction

endpackage

// File: rtl/fd_addr_gen.sv
// Maps a centre (x, y) and read index (0 = centre, 1..16 = circle) to a linear
// pixel address. The offset is added modulo 2^ADDR_W, so negative offsets wrap.
module fd_addr_gen
    import fd_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int ADDR_W = 15
) (
    input  logic [ADDR_W-1:0] xPos,
    input  logic [ADDR_W-1:0] yPos,
    input  logic [4:0]        readIdx,
    output logic [ADDR_W-1:0] addr
);

    logic [3:0]        slot;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] offs;

    always_comb begin
        slot = 4'(readIdx - 5'd1);
        base = yPos * ADDR_W'(IMG_W) + xPos;
        offs = '0;
        if (readIdx != 5'd0) begin
            offs = ADDR_W'(circOffset(int'(slot), IMG_W));
        end
        addr = base + offs;
    end

endmodule

// File: rtl/fd_scan_ctrl.sv
// Raster-scans candidate centres, fetches each centre plus its 16 circle pixels
// and hands the bundle to the segment-test datapath with a valid/ready handshake.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; threshold latched on acceptance
// S_FETCH   | 17 back-to-back reads: centre, then circle index 0..15
// S_WAIT    | no read; last circle byte arrives and is captured
// S_PRESENT | bundle valid, held until the datapath accepts it
// S_DONE    | one-cycle end-of-frame pulse, then back to idle
module fd_scan_ctrl
    import fd_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                thres_in,
    output logic                      mem_rd,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [7:0]                mem_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         ref_addr,
    output logic [7:0]                ref_pixel,
    output logic [PIX_W*NUM_CIRC-1:0] adj_pixel,
    output logic [7:0]                thres,
    output logic                      busy,
    output logic                      done
);

    localparam logic [ADDR_W-1:0] X_FIRST = ADDR_W'(RADIUS);
    localparam logic [ADDR_W-1:0] Y_FIRST = ADDR_W'(RADIUS);
    localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(IMG_W - 1 - RADIUS);
    localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(IMG_H - 1 - RADIUS);
    localparam logic [4:0]        IDX_LAST = 5'(NUM_READS - 1);

    fdState_t state, stateNext;

    logic [ADDR_W-1:0]         xPos, yPos;
    logic [4:0]                readIdx;
    logic                      captValid;
    logic [4:0]                captIdx;
    logic [3:0]                captSlot;
    logic [7:0]                thresReg;
    logic [ADDR_W-1:0]         refAddrReg;
    logic [7:0]                refPixReg;
    logic [PIX_W*NUM_CIRC-1:0] adjReg;
    logic [ADDR_W-1:0]         genAddr;
    logic                      rdNow;
    logic                      accept;
    logic                      lastCentre;

    fd_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .xPos    (xPos),
        .yPos    (yPos),
        .readIdx (readIdx),
        .addr    (genAddr)
    );

    assign lastCentre = (xPos == X_LAST) && (yPos == Y_LAST);
    assign captSlot   = 4'(captIdx - 5'd1);

    always_comb begin
        stateNext = state;
        rdNow     = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) stateNext = S_FETCH;
            end
            S_FETCH: begin
                rdNow = 1'b1;
                if (readIdx == IDX_LAST) stateNext = S_WAIT;
            end
            S_WAIT: begin
                stateNext = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready) begin
                    accept    = 1'b1;
                    stateNext = lastCentre ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    assign mem_rd    = rdNow;
    assign mem_addr  = rdNow ? genAddr : '0;
    assign out_valid = (state == S_PRESENT);
    assign busy      = (state == S_FETCH) || (state == S_WAIT) || (state == S_PRESENT);
    assign done      = (state == S_DONE);
    assign ref_addr  = refAddrReg;
    assign ref_pixel = refPixReg;
    assign adj_pixel = adjReg;
    assign thres     = thresReg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            xPos       <= '0;
            yPos       <= '0;
            readIdx    <= '0;
            captValid  <= 1'b0;
            captIdx    <= '0;
            thresReg   <= '0;
            refAddrReg <= '0;
            refPixReg  <= '0;
            adjReg     <= '0;
        end else begin
            state     <= stateNext;
            captValid <= rdNow;
            captIdx   <= readIdx;

            if (state == S_IDLE && start) begin
                thresReg <= thres_in;
                xPos     <= X_FIRST;
                yPos     <= Y_FIRST;
                readIdx  <= '0;
            end

            if (state == S_FETCH) begin
                readIdx <= readIdx + 5'd1;
                if (readIdx == 5'd0) refAddrReg <= genAddr;
            end

            if (accept && !lastCentre) begin
                readIdx <= '0;
                if (xPos == X_LAST) begin
                    xPos <= X_FIRST;
                    yPos <= yPos + ADDR_W'(1);
                end else begin
                    xPos <= xPos + ADDR_W'(1);
                end
            end

            // Read data lands one cycle after its strobe; slot follows the delayed index.
            if (captValid) begin
                if (captIdx == 5'd0) begin
                    refPixReg <= mem_data;
                end else begin
                    adjReg[{captSlot, 3'b000} +: PIX_W] <= mem_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fd_scan_ctrl.sv
// Scoreboard bench: a frame model built from the scan rules fills expected read
// and bundle queues; a negedge monitor checks every read and every presented bundle.
module tb_fd_scan_ctrl;

    localparam int W  = 11;
    localparam int H  = 9;
    localparam int AW = 15;
    localparam int DX [16] = '{ 0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    thres_in;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] ref_addr;
    logic [7:0]    ref_pixel;
    logic [127:0]  adj_pixel;
    logic [7:0]    thres;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    fd_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .thres_in  (thres_in),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ref_addr  (ref_addr),
        .ref_pixel (ref_pixel),
        .adj_pixel (adj_pixel),
        .thres     (thres),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int           addr;
        logic [7:0]   pix;
        logic [127:0] adj;
        logic [7:0]   thr;
    } bundle_t;

    bundle_t    expB[$];
    int         expA[$];
    logic [7:0] memArr [W*H];
    int         nTests = 0;
    int         nFail  = 0;
    bundle_t    monB;
    bit         doneDue = 1'b0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        nTests++;
        nFail++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Memory answers one cycle after the strobe; garbage otherwise.
    always @(posedge clock) begin
        if (mem_rd) mem_data <= memArr[mem_addr];
        else        mem_data <= 8'($urandom);
    end

    task automatic buildFrame(input logic [7:0] thr);
        bundle_t b;
        int c, a;
        for (int y = 3; y <= H - 4; y++) begin
            for (int x = 3; x <= W - 4; x++) begin
                c = y * W + x;
                b.addr = c;
                b.pix  = memArr[c];
                b.thr  = thr;
                b.adj  = '0;
                expA.push_back(c);
                for (int i = 0; i < 16; i++) begin
                    a = (y + DY[i]) * W + (x + DX[i]);
                    expA.push_back(a);
                    b.adj[8*i +: 8] = memArr[a];
                end
                expB.push_back(b);
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (doneDue) begin
                check("done_after_last_accept", {done, busy}, 2'b10);
                doneDue = 1'b0;
            end else begin
                check("done_low", done, 1'b0);
            end
            if (mem_rd) begin
                if (expA.size() == 0) failNow("unexpected_read");
                else check("mem_addr", mem_addr, expA.pop_front());
            end else begin
                check("mem_addr_idle", mem_addr, 0);
            end
            if (out_valid) begin
                check("mem_rd_in_present", {mem_rd, busy}, 2'b01);
                if (expB.size() == 0) begin
                    failNow("unexpected_bundle");
                end else begin
                    monB = expB[0];
                    check("ref_addr", ref_addr, monB.addr);
                    check("ref_pixel", ref_pixel, monB.pix);
                    check("adj_pixel", adj_pixel, monB.adj);
                    check("thres", thres, monB.thr);
                    if (out_ready) begin
                        void'(expB.pop_front());
                        if (expB.size() == 0) doneDue = 1'b1;
                    end
                end
            end
        end
    end

    // mode 0: ready always high; 1: random ready; 2: 50-cycle stall on first bundle.
    // abortAt >= 0: reset during the fetch of centre number abortAt+1.
    task automatic runFrame(input logic [7:0] thr, input int mode, input int abortAt);
        int cyc, firstValid, accepts, stallCnt, readCyc;
        bit sawDone;
        for (int a = 0; a < W * H; a++) memArr[a] = 8'($urandom);
        buildFrame(thr);
        @(posedge clock); #1;
        thres_in  = thr;
        start     = 1'b1;
        out_ready = (mode == 0);
        @(posedge clock); #1;
        start    = 1'b0;
        thres_in = 8'($urandom);
        check("busy_after_start", busy, 1'b1);
        cyc = 1; firstValid = 0; accepts = 0; stallCnt = 0; readCyc = 0; sawDone = 1'b0;
        while (cyc < 4000) begin
            if (done) begin
                sawDone = 1'b1;
                break;
            end
            if (out_valid && firstValid == 0) firstValid = cyc;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (out_valid && stallCnt < 50) begin
                        out_ready = 1'b0;
                        stallCnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            start    = (cyc == 5) || (mode == 1 && $urandom_range(0, 15) == 0);
            thres_in = 8'($urandom);
            if (abortAt >= 0 && accepts == abortAt && mem_rd) begin
                readCyc++;
                if (readCyc == 6) begin
                    reset = 1'b1;
                    start = 1'b0;
                    @(posedge clock); #1;
                    expA.delete();
                    expB.delete();
                    check("outputs_zero_after_reset",
                          {mem_rd, mem_addr, out_valid, ref_addr, ref_pixel, adj_pixel, thres, busy, done}, 0);
                    reset     = 1'b0;
                    out_ready = 1'b0;
                    return;
                end
            end
            if (out_valid && out_ready) accepts++;
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        if (!sawDone) failNow("frame_timeout");
        check("busy_low_in_done", busy, 1'b0);
        if (mode == 0) check("first_valid_latency", firstValid, 19);
        if (mode == 2) check("stall_cycles", stallCnt, 50);
        @(posedge clock); #1;
        check("done_single_pulse", {done, busy}, 2'b00);
        check("bundles_left", expB.size(), 0);
        check("reads_left", expA.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        thres_in  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs",
              {mem_rd, mem_addr, out_valid, ref_addr, ref_pixel, adj_pixel, thres, busy, done}, 0);
        reset = 1'b0;

        runFrame(8'h20, 0, -1);
        runFrame(8'h37, 1, -1);
        runFrame(8'h5a, 2, -1);
        runFrame(8'h11, 0, 2);
        runFrame(8'h20, 0, -1);
        runFrame(8'hc4, 1, -1);

        @(posedge clock); #1;
        reset    = 1'b1;
        start    = 1'b1;
        thres_in = 8'h55;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        check("reset_beats_start", {busy, thres}, 0);
        @(posedge clock); #1;
        check("no_start_after_reset", {busy, mem_rd}, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fd_scan_ctrl.md
FD_SCAN_CTRL -- requirements
Module: fd_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 128, image width in pixels (min 7).
REQ-002 SHALL have parameter IMG_H, default 128, image height in pixels (min 7).
REQ-003 SHALL have parameter ADDR_W, default 15, pixel memory address width.
REQ-004 SHALL have port clock  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  frame start request, sampled only in IDLE.
REQ-007 SHALL have port thres_in  in  8  corner threshold, latched when start is accepted.
REQ-008 SHALL have port mem_rd  out  1  pixel memory read strobe.
REQ-009 SHALL have port mem_addr  out  ADDR_W  pixel memory read address, y*IMG_W+x.
REQ-010 SHALL have port mem_data  in  8  read data, valid exactly 1 cycle after mem_rd.
REQ-011 SHALL have port out_valid  out  1  candidate bundle valid toward segment-test datapath.
REQ-012 SHALL have port out_ready  in  1  datapath accepts bundle.
REQ-013 SHALL have port ref_addr  out  ADDR_W  address of centre pixel.
REQ-014 SHALL have port ref_pixel  out  8  centre pixel value.
REQ-015 SHALL have port adj_pixel  out  128  16 circle pixels; byte i = adj_pixel[8i+7:8i].
REQ-016 SHALL have port thres  out  8  latched threshold.
REQ-017 SHALL have port busy  out  1  high from start acceptance until done.
REQ-018 SHALL have port done  out  1  one-cycle end-of-frame pulse.

Function
REQ-019 SHALL scan centres in raster order, x = 3..IMG_W-4 inner, y = 3..IMG_H-4 outer (radius-3 border skipped).
REQ-020 SHALL use circle offsets (dx,dy), index 0..15: (0,-3)(1,-3)(2,-2)(3,-1)(3,0)(3,1)(2,2)(1,3)(0,3)(-1,3)(-2,2)(-3,1)(-3,0)(-3,-1)(-2,-2)(-1,-3).
REQ-021 SHALL implement states IDLE, FETCH, WAIT, PRESENT, DONE.
REQ-022 IDLE: start=1 -> latch thres_in, set x=y=3, go FETCH; busy=1 from next cycle.
REQ-023 FETCH: 17 consecutive cycles with mem_rd=1; read 0 = centre, reads 1..16 = circle index 0..15; then WAIT.
REQ-024 WAIT: one cycle, mem_rd=0, capture final circle byte; then PRESENT.
REQ-025 Each returned byte SHALL be written to its slot in the cycle it is valid; no slot written twice per centre.
REQ-026 PRESENT: out_valid=1; ref_addr, ref_pixel, adj_pixel, thres SHALL stay stable until out_ready=1.
REQ-027 Accept (out_valid&out_ready): if last centre -> DONE, else advance x (wrap to 3, y+1) -> FETCH next cycle.
REQ-028 DONE: done=1 for one cycle, busy=0 in that cycle, then IDLE.
REQ-029 Latency: out_valid SHALL rise 19 cycles after the edge that accepts start; per-centre period 19 cycles with out_ready held 1.
REQ-030 start outside IDLE SHALL be ignored; thres SHALL not change mid-frame.
REQ-031 mem_rd SHALL be 0 in IDLE, WAIT, PRESENT, DONE; mem_addr don't-care but driven 0 when mem_rd=0.
REQ-032 Address arithmetic SHALL be unsigned ADDR_W bits; offsets never leave the image given REQ-019.
REQ-033 IMG_W=IMG_H=7 SHALL produce exactly one centre (3,3).

Reset
REQ-034 reset=1 at any edge, including mid-frame, SHALL force IDLE and zero every output and the x/y counters and bundle registers on the next cycle.
REQ-035 reset SHALL take priority over start and out_ready in the same cycle.

Structure
REQ-036 Package fd_pkg SHALL hold the state enum, PIX_W=8, NUM_CIRC=16, RADIUS=3 and the circle offset table.
REQ-037 One sub-module fd_addr_gen SHALL map (x, y, read index 0..16) to mem_addr combinationally.

Verification
REQ-038 7x7, mem[a]=a[7:0], out_ready=1: one bundle, ref_addr=24, ref_pixel=0x18, byte0=0x03, byte4=0x1B, byte8=0x2D; done 1 cycle after accept.
REQ-039 Same setup: mem_rd high 17 cycles, addresses 24,3,4,12,20,27,34,40,... ; out_valid rises exactly 19 cycles after start edge.
REQ-040 out_ready held 0 for 50 cycles in PRESENT -> outputs bit-stable, mem_rd=0, no advance.
REQ-041 reset asserted during FETCH of 3rd centre -> all outputs 0 next cycle; new start restarts at ref_addr=3*IMG_W+3.
REQ-042 start pulsed while busy and thres_in changed 0x20->0x40 mid-frame -> ignored; thres stays 0x20.
REQ-043 128x128, out_ready=1 -> 14884 accepts, last ref_addr=15996, one done pulse, busy then 0.
